// File: rtl/ifid_stage_if.sv
// Instruction-cache request/response channel between the IF/ID stage (master)
// and the instruction cache (slave).
interface ifid_stage_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
);
  logic                   ReqValid;
  logic [ADDR_WIDTH-1:0]  ReqAddr;
  logic                   ReqReady;
  logic                   RspValid;
  logic [INSTR_WIDTH-1:0] RspData;

  modport master (output ReqValid, ReqAddr, input ReqReady, RspValid, RspData);
  modport slave  (input ReqValid, ReqAddr, output ReqReady, RspValid, RspData);
endinterface

// File: rtl/ifid_stage.sv
// IF/ID stage: issues I-cache requests for Fetch, buffers in-order responses
// and presents them to Decode; drops stale fetches after a flush.
module ifid_stage #(
  parameter int                     ADDR_WIDTH  = 32,
  parameter int                     INSTR_WIDTH = 32,
  parameter int                     BUF_DEPTH   = 2,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(32'h00000013)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WIDTH-1:0]  Fetch_NextPC,
  output logic                   Fetch_Stall,
  ifid_stage_if.master           icache,
  input  logic                   Flush,
  input  logic                   Decode_Stall,
  output logic [ADDR_WIDTH-1:0]  IFID_NowPC,
  output logic [INSTR_WIDTH-1:0] IFID_Instr,
  output logic                   IFID_Valid
);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = $clog2(BUF_DEPTH);

  logic [CW-1:0] outCnt, bufCnt, discCnt;
  logic [PW-1:0] pqWr, pqRd, bWr, bRd;
  logic [ADDR_WIDTH-1:0]  pcQ      [BUF_DEPTH];
  logic [ADDR_WIDTH-1:0]  bufPc    [BUF_DEPTH];
  logic [INSTR_WIDTH-1:0] bufInstr [BUF_DEPTH];

  logic [CW:0] occ;
  logic reqValid, accept, rspKeep, rspDrop, outLoad, bufEmpty, deq, bypass, bufPush;

  always_comb begin
    occ      = {1'b0, outCnt} + {1'b0, bufCnt};
    reqValid = ~Flush & (occ < (CW+1)'(BUF_DEPTH));
    accept   = reqValid & icache.ReqReady;
    // A response seen during Flush is stale by definition and never kept.
    rspKeep  = icache.RspValid & ~Flush & (discCnt == '0);
    rspDrop  = icache.RspValid & ~Flush & (discCnt != '0);
    outLoad  = ~Flush & ~Decode_Stall;
    bufEmpty = (bufCnt == '0);
    deq      = outLoad & ~bufEmpty;
    bypass   = rspKeep & bufEmpty & outLoad;
    bufPush  = rspKeep & ~bypass;
  end

  assign icache.ReqValid = reqValid;
  assign icache.ReqAddr  = Fetch_NextPC;
  assign Fetch_Stall     = ~accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outCnt  <= '0;
      bufCnt  <= '0;
      discCnt <= '0;
      pqWr    <= '0;
      pqRd    <= '0;
      bWr     <= '0;
      bRd     <= '0;
    end else if (Flush) begin
      // Every outstanding request is now stale; one landing this cycle is already gone.
      outCnt  <= outCnt - CW'(icache.RspValid);
      discCnt <= outCnt - CW'(icache.RspValid);
      bufCnt  <= '0;
      pqWr    <= '0;
      pqRd    <= '0;
      bWr     <= '0;
      bRd     <= '0;
    end else begin
      outCnt <= outCnt + CW'(accept) - CW'(icache.RspValid);
      bufCnt <= bufCnt + CW'(bufPush) - CW'(deq);
      if (rspDrop) discCnt <= discCnt - CW'(1);
      if (accept)  pqWr    <= pqWr + PW'(1);
      if (rspKeep) pqRd    <= pqRd + PW'(1);
      if (bufPush) bWr     <= bWr + PW'(1);
      if (deq)     bRd     <= bRd + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) pcQ[pqWr] <= Fetch_NextPC;
    if (bufPush) begin
      bufPc[bWr]    <= pcQ[pqRd];
      bufInstr[bWr] <= icache.RspData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      IFID_Valid <= 1'b0;
      IFID_Instr <= NOP_INSTR;
      IFID_NowPC <= '0;
    end else if (Flush) begin
      IFID_Valid <= 1'b0;
      IFID_Instr <= NOP_INSTR;
    end else if (!Decode_Stall) begin
      if (!bufEmpty) begin
        IFID_Valid <= 1'b1;
        IFID_Instr <= bufInstr[bRd];
        IFID_NowPC <= bufPc[bRd];
      end else if (rspKeep) begin
        IFID_Valid <= 1'b1;
        IFID_Instr <= icache.RspData;
        IFID_NowPC <= pcQ[pqRd];
      end else begin
        IFID_Valid <= 1'b0;
        IFID_Instr <= NOP_INSTR;
      end
    end
  end
endmodule

// File: doc/ifid_stage.md
Name: ifid_stage

Overview:
Sits between Fetch and Decode. It issues instruction-cache requests for Fetch_NextPC and stalls Fetch until each request is accepted. Responses are queued in a small in-order buffer and presented to Decode through the IF/ID output register (IFID_NowPC, IFID_Instr, IFID_Valid). It discards in-flight and buffered fetches on branch or exception flush.

Parameters:
ADDR_WIDTH, 32, PC/address width
INSTR_WIDTH, 32, fetched instruction width
BUF_DEPTH, 2, maximum of outstanding requests plus buffered responses (power of 2, >=2)
NOP_INSTR, 32'h00000013, instruction driven when IFID_Valid=0

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
Fetch_NextPC  in  ADDR_WIDTH  PC to fetch, from Fetch
Fetch_Stall  out  1  to Fetch Stall input; high when no request is accepted this cycle
Icache_ReqValid  out  1  request valid
Icache_ReqAddr  out  ADDR_WIDTH  request address (= Fetch_NextPC)
Icache_ReqReady  in  1  cache accepts request
Icache_RspValid  in  1  response valid (in order, >=1 cycle after acceptance)
Icache_RspData  in  INSTR_WIDTH  response instruction
Flush  in  1  EX_BranchFlag | Ctrl_ExcpFlag
Decode_Stall  in  1  hold IF/ID output
IFID_NowPC  out  ADDR_WIDTH  PC of presented instruction
IFID_Instr  out  INSTR_WIDTH  presented instruction
IFID_Valid  out  1  presented instruction valid

Behaviour:
- Reset (async, rst=1): IFID_Valid=0, IFID_Instr=NOP_INSTR, IFID_NowPC=0. Outstanding count, buffer count and discard count are 0; buffer is empty. The cache is reset together with this block, so no stale responses arrive after reset.
- State:
  - out_cnt: accepted requests awaiting response.
  - buf: BUF_DEPTH-entry FIFO of {PC, instr}; buf_cnt.
  - pc_q: FIFO of PCs for outstanding requests.
  - disc_cnt: responses still to be dropped.
- Request rule:
  - Icache_ReqValid = ~Flush & (out_cnt + buf_cnt < BUF_DEPTH).
  - Accept = ReqValid & ReqReady; on accept, push Fetch_NextPC into pc_q and increment out_cnt.
  - Fetch_Stall = ~Accept (combinational).
- Response rule (RspValid):
  - If disc_cnt>0: drop the response, decrement disc_cnt and out_cnt.
  - Otherwise: pop pc_q, decrement out_cnt, and write {pc, data} into buf. Bypass: if buf is empty and the output register loads this cycle, load the response directly.
- Output register, evaluated each edge, in priority order:
  1. Flush: IFID_Valid<=0, IFID_Instr<=NOP_INSTR, IFID_NowPC held.
  2. Decode_Stall: hold all outputs.
  3. buf non-empty: load the head and pop it.
  4. Bypass response available: load it.
  5. Otherwise: IFID_Valid<=0, IFID_Instr<=NOP_INSTR.
- Latency: accept at cycle N, response at N+k, IFID_Valid=1 at N+k+1 when not stalled.
- Flush:
  - buf is emptied and pc_q is cleared.
  - disc_cnt <= out_cnt minus 1 if a response arrives in the same cycle (that response is also dropped).
  - ReqValid is low during the Flush cycle. Fetch loads the redirect PC at that edge, so the first post-flush request is the target PC.
- Simultaneous events:
  - Accept and response in the same cycle: out_cnt unchanged.
  - Response and dequeue in the same cycle: buf_cnt unchanged.
  - Flush with Decode_Stall: Flush wins.
- Full: out_cnt + buf_cnt = BUF_DEPTH gives ReqValid=0 and Fetch_Stall=1. It frees one cycle after a dequeue or a dropped response.
- FIFO pointers wrap modulo BUF_DEPTH. Counts never exceed BUF_DEPTH or go negative.
- Reset mid-operation: everything is cleared immediately, independent of clk.

Test Plan:
- Single fetch: release reset, PC=0x80000000, ReqReady=1, response 0x00A00093 one cycle later. Required: IFID_Valid=1, IFID_NowPC=0x80000000, IFID_Instr=0x00A00093 on the following cycle.
- Backpressure: ReqReady=0 for 3 cycles. Required: Fetch_Stall=1 for 3 cycles and Fetch_NextPC unchanged; Fetch_Stall=0 on the cycle ReqReady rises.
- Full buffer: Decode_Stall=1, two requests answered. Required: ReqValid=0 and Fetch_Stall=1. On release, PCs 0x80000000 then 0x80000004 appear on consecutive cycles.
- Flush with 2 outstanding: Flush pulsed, then both stale responses arrive. Required: both dropped, IFID_Valid=0 throughout, then branch target 0x80000100 presented.
- Flush coincident with a response: that response is dropped, disc_cnt=1, and the next response is also dropped.
- Async reset mid-stream: rst asserted between edges. Required: IFID_Valid=0 and IFID_Instr=0x00000013 immediately, with counts 0 after release.
